// File: rtl/arith_unit_seq.sv
// Sequential arithmetic unit: ADD/SUB/MOV in 1 cycle, MOD/MUL iterate one bit per cycle (N cycles).
// ready_o is low while an iterative op runs; starts are dropped then, and results are never held back.
module arith_unit_seq #(
   parameter int N = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         start_i,
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic [2:0]   opcode_i,
   output logic         ready_o,
   output logic         valid_o,
   output logic [N-1:0] result_o,
   output logic         carry_o,
   output logic         zero_o,
   output logic         dbz_o
);

   localparam logic [2:0] ARITH_ADD = 3'd0;
   localparam logic [2:0] ARITH_SUB = 3'd1;
   localparam logic [2:0] ARITH_MOD = 3'd2;
   localparam logic [2:0] MOV_      = 3'd3;
   localparam logic [2:0] ARITH_MUL = 3'd4;
   localparam int         CW        = $clog2(N + 1);

   typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic             r_is_mul;
   logic [N-1:0]     r_a;
   logic [N-1:0]     r_b;
   logic [N-1:0]     r_rem;
   logic [2*N-1:0]   r_mcand;
   logic [2*N-1:0]   r_acc;
   logic             r_valid;
   logic [N-1:0]     r_result;
   logic             r_carry;
   logic             r_zero;
   logic             r_dbz;

   logic             w_accept;
   logic             w_multi;
   logic [N:0]       w_sum;
   logic [N:0]       w_diff;
   logic [N-1:0]     w_sc_res;
   logic             w_sc_carry;
   logic [N:0]       w_rem_sh;
   logic [N-1:0]     w_rem_nx;
   logic [2*N-1:0]   w_acc_nx;
   logic [N-1:0]     w_it_res;

   assign w_accept = start_i && (r_state == S_IDLE);
   assign w_multi  = (opcode_i == ARITH_MOD) || (opcode_i == ARITH_MUL);
   assign w_sum    = {1'b0, a_i} + {1'b0, b_i};
   assign w_diff   = {1'b0, a_i} - {1'b0, b_i};

   always_comb begin
      w_sc_res   = '0;
      w_sc_carry = 1'b0;
      case (opcode_i)
         ARITH_ADD: begin w_sc_res = w_sum[N-1:0];  w_sc_carry = w_sum[N];  end
         ARITH_SUB: begin w_sc_res = w_diff[N-1:0]; w_sc_carry = w_diff[N]; end
         MOV_:      w_sc_res = b_i;
         default:   ;
      endcase
   end

   // Restoring remainder step; a zero divisor never restores, so the dividend falls out unchanged.
   assign w_rem_sh = {r_rem, r_a[N-1]};
   assign w_rem_nx = (w_rem_sh >= {1'b0, r_b}) ? N'(w_rem_sh - {1'b0, r_b}) : w_rem_sh[N-1:0];
   assign w_acc_nx = r_b[0] ? (r_acc + r_mcand) : r_acc;
   assign w_it_res = r_is_mul ? w_acc_nx[N-1:0] : w_rem_nx;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_is_mul <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_rem    <= '0;
         r_mcand  <= '0;
         r_acc    <= '0;
         r_valid  <= 1'b0;
         r_result <= '0;
         r_carry  <= 1'b0;
         r_zero   <= 1'b0;
         r_dbz    <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept && w_multi) begin
                  r_state  <= S_BUSY;
                  r_cnt    <= CW'(N);
                  r_is_mul <= (opcode_i == ARITH_MUL);
                  r_a      <= a_i;
                  r_b      <= b_i;
                  r_rem    <= '0;
                  r_mcand  <= {{N{1'b0}}, a_i};
                  r_acc    <= '0;
               end else if (w_accept) begin
                  r_valid  <= 1'b1;
                  r_result <= w_sc_res;
                  r_carry  <= w_sc_carry;
                  r_zero   <= (w_sc_res == '0);
                  r_dbz    <= 1'b0;
               end
            end
            S_BUSY: begin
               r_cnt   <= r_cnt - CW'(1);
               r_a     <= {r_a[N-2:0], 1'b0};
               r_rem   <= w_rem_nx;
               r_mcand <= {r_mcand[2*N-2:0], 1'b0};
               r_acc   <= w_acc_nx;
               if (r_is_mul) r_b <= {1'b0, r_b[N-1:1]};
               if (r_cnt == CW'(1)) begin
                  r_state  <= S_IDLE;
                  r_valid  <= 1'b1;
                  r_result <= w_it_res;
                  r_carry  <= r_is_mul && (w_acc_nx[2*N-1:N] != '0);
                  r_zero   <= (w_it_res == '0);
                  r_dbz    <= !r_is_mul && (r_b == '0);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ready_o  = (r_state == S_IDLE);
   assign valid_o  = r_valid;
   assign result_o = r_result;
   assign carry_o  = r_carry;
   assign zero_o   = r_zero;
   assign dbz_o    = r_dbz;

endmodule

// File: tb/tb_arith_unit_seq.sv
// Directed plus randomized bench for arith_unit_seq; expected values come from plain-arithmetic model.
module tb_arith_unit_seq;

   localparam int N = 8;
   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MOD = 3'd2;
   localparam logic [2:0] OP_MOV = 3'd3;
   localparam logic [2:0] OP_MUL = 3'd4;

   logic         clk_i = 1'b0;
   logic         rst_ni;
   logic         start_i;
   logic [N-1:0] a_i;
   logic [N-1:0] b_i;
   logic [2:0]   opcode_i;
   logic         ready_o;
   logic         valid_o;
   logic [N-1:0] result_o;
   logic         carry_o;
   logic         zero_o;
   logic         dbz_o;

   int checks = 0;
   int passes = 0;

   arith_unit_seq #(.N(N)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .a_i(a_i), .b_i(b_i),
      .opcode_i(opcode_i), .ready_o(ready_o), .valid_o(valid_o), .result_o(result_o),
      .carry_o(carry_o), .zero_o(zero_o), .dbz_o(dbz_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) begin
         passes++;
      end else begin
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag, input bit ev, input int unsigned er, input bit ec,
                             input bit ez, input bit edz, input bit erdy);
      chk({tag, ".valid"},  32'(valid_o),  32'(ev));
      chk({tag, ".result"}, 32'(result_o), er);
      chk({tag, ".carry"},  32'(carry_o),  32'(ec));
      chk({tag, ".zero"},   32'(zero_o),   32'(ez));
      chk({tag, ".dbz"},    32'(dbz_o),    32'(edz));
      chk({tag, ".ready"},  32'(ready_o),  32'(erdy));
   endtask

   function automatic void model(input logic [2:0] op, input int unsigned a, input int unsigned b,
                                 output int unsigned res, output bit c, output bit dz);
      int unsigned m = 32'd1 << N;
      int unsigned t;
      res = 0; c = 0; dz = 0;
      case (op)
         OP_ADD: begin t = a + b; res = t % m; c = (t >= m); end
         OP_SUB: begin res = (a + m - b) % m; c = (a < b); end
         OP_MOV: res = b;
         OP_MOD: begin
            if (b == 0) begin res = a; dz = 1; end
            else res = a % b;
         end
         OP_MUL: begin t = a * b; res = t % m; c = ((t / m) != 0); end
         default: ;
      endcase
   endfunction

   // Drives one request, scrambles the inputs while busy, checks latency, outputs, and the idle cycle after.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [N-1:0] a,
                         input logic [N-1:0] b, input int unsigned er, input bit ec,
                         input bit edz, input bit inject);
      bit multi = (op == OP_MOD) || (op == OP_MUL);
      int low = 0;
      opcode_i = op; a_i = a; b_i = b; start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0; a_i = N'($urandom); b_i = N'($urandom); opcode_i = 3'($urandom);
      if (multi) begin
         for (int i = 0; i < N; i++) begin
            if (ready_o === 1'b0 && valid_o === 1'b0) low++;
            if (inject && i == 2) begin start_i = 1'b1; opcode_i = OP_ADD; end
            else start_i = 1'b0;
            @(negedge clk_i);
         end
         chk({tag, ".busy_cycles"}, 32'(low), 32'(N));
      end
      check_outs(tag, 1'b1, er, ec, (er == 0), edz, 1'b1);
      @(negedge clk_i);
      chk({tag, ".no_extra_valid"}, 32'(valid_o), 32'd0);
   endtask

   task automatic run_rand(input string tag, input logic [2:0] op, input logic [N-1:0] a,
                           input logic [N-1:0] b);
      int unsigned er;
      bit ec, edz;
      model(op, a, b, er, ec, edz);
      run_op(tag, op, a, b, er, ec, edz, 1'b0);
   endtask

   initial begin
      int vcount;
      rst_ni = 1'b0; start_i = 1'b0; a_i = '0; b_i = '0; opcode_i = '0;
      @(negedge clk_i);
      @(negedge clk_i);
      check_outs("reset", 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      rst_ni = 1'b1;
      @(negedge clk_i);

      run_op("add_200_100", OP_ADD, 8'd200, 8'd100, 44, 1'b1, 1'b0, 1'b0);

      // SUB then MOV back to back: one result per cycle
      opcode_i = OP_SUB; a_i = 8'd5; b_i = 8'd7; start_i = 1'b1;
      @(negedge clk_i);
      check_outs("sub_5_7", 1'b1, 254, 1'b1, 1'b0, 1'b0, 1'b1);
      opcode_i = OP_MOV; a_i = 8'd99; b_i = 8'd0;
      @(negedge clk_i);
      start_i = 1'b0;
      check_outs("mov_0", 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1);
      @(negedge clk_i);
      chk("mov_0.valid_drops", 32'(valid_o), 32'd0);

      run_op("mod_200_7", OP_MOD, 8'd200, 8'd7, 4, 1'b0, 1'b0, 1'b1);
      run_op("mod_13_0", OP_MOD, 8'd13, 8'd0, 13, 1'b0, 1'b1, 1'b0);
      run_op("add_1_1", OP_ADD, 8'd1, 8'd1, 2, 1'b0, 1'b0, 1'b0);
      run_op("mul_20_13", OP_MUL, 8'd20, 8'd13, 4, 1'b1, 1'b0, 1'b0);
      run_op("mul_15_17", OP_MUL, 8'd15, 8'd17, 255, 1'b0, 1'b0, 1'b0);
      run_op("undef_op", 3'd6, 8'd9, 8'd9, 0, 1'b0, 1'b0, 1'b0);
      run_op("mov_255", OP_MOV, 8'd0, 8'd255, 255, 1'b0, 1'b0, 1'b0);

      // Reset in the middle of a MOD aborts it with no completion pulse
      opcode_i = OP_MOD; a_i = 8'd200; b_i = 8'd7; start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      check_outs("rst_mid", 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      vcount = 0;
      for (int i = 0; i < N + 2; i++) begin
         @(negedge clk_i);
         if (valid_o !== 1'b0) vcount++;
      end
      chk("rst_mid.no_valid", 32'(vcount), 32'd0);
      run_op("add_3_4", OP_ADD, 8'd3, 8'd4, 7, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         logic [2:0]   op;
         logic [N-1:0] ra, rb;
         op = 3'($urandom_range(0, 7));
         ra = N'($urandom);
         rb = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom);
         run_rand($sformatf("rand%0d_op%0d_%0d_%0d", i, op, ra, rb), op, ra, rb);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/arith_unit_seq.md
Name: arith_unit_seq

Overview:
Parametrised, multi-cycle successor to the pipeline's combinational arithmetic unit, for the RSA pipeline CPU execute stage.
- ADD, SUB and MOV complete in one cycle.
- ARITH_MOD runs as an iterative restoring remainder.
- New op ARITH_MUL runs as an iterative shift-add multiply.
- A start/ready/valid handshake lets the pipeline stall on long ops.
- Adds status flags (carry/borrow, zero, divide-by-zero) that the combinational unit lacks.

Parameters:
- N, 8, operand and result width in bits (N >= 2).

Ports:
- clk_i  input  1  single clock, rising edge.
- rst_ni  input  1  reset, asynchronous assert, active-low.
- start_i  input  1  request; accepted on a rising edge where start_i && ready_o.
- a_i  input  N  operand A, sampled at accept.
- b_i  input  N  operand B / divisor / multiplier, sampled at accept.
- opcode_i  input  3  alu_defs code (ARITH_ADD, ARITH_SUB, ARITH_MOD, MOV_, ARITH_MUL), sampled at accept.
- ready_o  output  1  unit can accept a request this cycle.
- valid_o  output  1  one-cycle pulse: result_o and flags are new.
- result_o  output  N  result, held until the next completion.
- carry_o  output  1  ADD carry-out / SUB borrow / MUL overflow.
- zero_o  output  1  result_o == 0.
- dbz_o  output  1  last completed op was ARITH_MOD with b == 0.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset value of every output:
  - State IDLE, ready_o=1.
  - valid_o=0, result_o=0, carry_o=0, zero_o=0, dbz_o=0.
  - Internal counter and operand registers cleared.
- Reset asserted mid-operation: aborts immediately with the reset values above. No completion pulse for the aborted op.
- States: IDLE, BUSY.
  - ready_o = (state == IDLE).
  - valid_o, result_o and the flags are registered; they are not a state.
- Single-cycle ops (ADD, SUB, MOV_, any undefined opcode): accepted at edge k → valid_o=1 in the cycle after edge k. State stays IDLE, so back-to-back accepts give 1 result/cycle.
  - ADD: result = (a+b)[N-1:0]; carry = bit N of the N+1-bit sum.
  - SUB: result = (a-b) mod 2^N; carry = (a < b).
  - MOV_: result = b; carry = 0.
  - Undefined opcode: result = 0; carry = 0.
- Multi-cycle ops (ARITH_MOD, ARITH_MUL):
  - Accept at edge k → BUSY. The counter is loaded with N and decrements once per edge.
  - One bit is processed per cycle, MSB-first for MOD, LSB-first for MUL.
  - Completion registered at edge k+N: valid_o=1 and state=IDLE in that same cycle, so ready_o=1 while valid_o=1.
  - Latency is N cycles; ready_o is low for exactly N cycles.
- ARITH_MOD:
  - result = a mod b, using an N+1-bit partial remainder.
  - b == 0: result = a, dbz_o=1, same N-cycle latency.
  - carry = 0.
- ARITH_MUL:
  - result = (a*b)[N-1:0], using a 2N-bit accumulator.
  - carry = 1 if (a*b)[2N-1:N] != 0.
- Flags: zero_o always equals (result == 0). dbz_o=0 for every completion except MOD-by-zero. All flags update only on completion.
- Requests while BUSY: start_i ignored and not queued; operand inputs ignored.
- valid_o is never high two cycles running for a multi-cycle op. For single-cycle ops it stays high on consecutive cycles only with back-to-back accepts.
- No output backpressure: the consumer must capture on valid_o.

Test Plan:
- ADD a=200, b=100, accept at edge k → cycle after k: valid_o=1, result_o=44, carry_o=1, zero_o=0; ready_o stays 1.
- SUB a=5, b=7 immediately followed by MOV_ b=0 → result_o=254 with carry_o=1, then next cycle result_o=0 with zero_o=1; valid_o high two consecutive cycles.
- MOD a=200, b=7:
  - ready_o=0 for 8 cycles; valid_o=1 after edge k+8 with result_o=4, dbz_o=0.
  - start_i pulsed with ADD at k+3 is ignored (no extra valid_o).
- MOD a=13, b=0 → after 8 cycles result_o=13, dbz_o=1. A following ADD 1+1 → result_o=2, dbz_o=0.
- MUL a=20, b=13 → after 8 cycles result_o=4, carry_o=1. MUL a=15, b=17 → result_o=255, carry_o=0.
- Assert rst_ni low at k+4 of a MOD → outputs 0 and ready_o=1 immediately, with no valid_o afterwards. After release, ADD 3+4 → result_o=7 one cycle after accept.
